// File: rtl/gem_match_scheduler.sv
// Time-multiplexed ALCT/CLCT/GEM position matcher: walks 16 GEM clusters through one
// shared window comparator and reports the best ALCT-CLCT pairing.
module gem_match_scheduler #(
   parameter int unsigned MXCLUSTER_CHAMBER = 8,
   parameter int unsigned MXADR             = 4
) (
   input  logic             i_clock,
   input  logic             i_reset,
   input  logic             i_start,
   input  logic             i_match_en,
   input  logic             i_alct0_vpf,
   input  logic             i_alct1_vpf,
   input  logic [6:0]       i_alct0_wg,
   input  logic [6:0]       i_alct1_wg,
   input  logic             i_clct0_vpf,
   input  logic             i_clct1_vpf,
   input  logic [9:0]       i_clct0_xky,
   input  logic [9:0]       i_clct1_xky,
   output logic             o_clu_rd_en,
   output logic [MXADR-1:0] o_clu_rd_adr,
   input  logic             i_clu_vpf,
   input  logic [6:0]       i_clu_wg_lo,
   input  logic [6:0]       i_clu_wg_hi,
   input  logic [9:0]       i_clu_xky_lo,
   input  logic [9:0]       i_clu_xky_hi,
   input  logic             i_clu_copad,
   output logic             o_busy,
   output logic             o_done,
   output logic [3:0]       o_pair_gem_hit,
   output logic [3:0]       o_pair_copad_hit,
   output logic [3:0]       o_pri_best,
   output logic [MXADR-1:0] o_best_cluster,
   output logic             o_start_lost
);

   localparam logic [MXADR-1:0] LastAdr  = MXADR'(2 * MXCLUSTER_CHAMBER - 1);
   localparam logic [MXADR-1:0] GemBAdr  = MXADR'(MXCLUSTER_CHAMBER);

   typedef enum logic [1:0] {StIdle, StRead, StDrain, StEncode} state_t;

   state_t                     r_state, w_state_nxt;
   logic                       w_accept;
   logic [MXADR-1:0]           r_adr;
   logic                       r_dvalid;
   logic [MXADR-1:0]           r_dadr;

   logic [1:0]                 r_alct_vpf, r_clct_vpf;
   logic [1:0][6:0]            r_alct_wg;
   logic [1:0][9:0]            r_clct_xky;
   logic                       r_match_en;

   logic [3:0]                 r_gem_hit, r_copad_hit;
   logic [3:0][MXADR-1:0]      r_gem_adr, r_copad_adr;

   logic [1:0]                 w_alct_m, w_clct_m;
   logic [3:0]                 w_pair_hit, w_copad_hit;
   logic [3:0]                 w_gem_nxt, w_copad_nxt;
   logic [3:0][MXADR-1:0]      w_gem_adr_nxt, w_copad_adr_nxt;
   logic [1:0]                 w_idx;
   logic [3:0]                 w_pri;
   logic [MXADR-1:0]           w_best;

   logic                       r_done;
   logic [3:0]                 r_pair_gem_hit, r_pair_copad_hit, r_pri_best;
   logic [MXADR-1:0]           r_best_cluster;
   logic                       r_start_lost;

   always_comb begin
      w_state_nxt = r_state;
      w_accept    = 1'b0;
      o_busy      = 1'b1;
      o_clu_rd_en = 1'b0;
      unique case (r_state)
         StIdle: begin
            o_busy = 1'b0;
            if (i_start) begin
               w_accept    = 1'b1;
               w_state_nxt = StRead;
            end
         end
         StRead: begin
            o_clu_rd_en = 1'b1;
            if (r_adr == LastAdr) w_state_nxt = StDrain;
         end
         StDrain:  w_state_nxt = StEncode;
         StEncode: w_state_nxt = StIdle;
         default:  w_state_nxt = StIdle;
      endcase
   end

   // Compare stage works on the data returned for the address issued last cycle.
   always_comb begin
      w_alct_m = '0;
      w_clct_m = '0;
      if (r_dvalid && i_clu_vpf) begin
         w_alct_m[0] = r_alct_vpf[0] && (i_clu_wg_lo <= r_alct_wg[0]) &&
                       (r_alct_wg[0] <= i_clu_wg_hi);
         w_alct_m[1] = r_alct_vpf[1] && (i_clu_wg_lo <= r_alct_wg[1]) &&
                       (r_alct_wg[1] <= i_clu_wg_hi);
         w_clct_m[0] = r_clct_vpf[0] && (i_clu_xky_lo <= r_clct_xky[0]) &&
                       (r_clct_xky[0] <= i_clu_xky_hi);
         w_clct_m[1] = r_clct_vpf[1] && (i_clu_xky_lo <= r_clct_xky[1]) &&
                       (r_clct_xky[1] <= i_clu_xky_hi);
      end
      w_pair_hit  = {w_alct_m[1] & w_clct_m[1], w_alct_m[1] & w_clct_m[0],
                     w_alct_m[0] & w_clct_m[1], w_alct_m[0] & w_clct_m[0]} & {4{r_match_en}};
      w_copad_hit = (i_clu_copad && (r_dadr < GemBAdr)) ? w_pair_hit : 4'b0000;
   end

   always_comb begin
      w_gem_nxt       = r_gem_hit | w_pair_hit;
      w_copad_nxt     = r_copad_hit | w_copad_hit;
      w_gem_adr_nxt   = r_gem_adr;
      w_copad_adr_nxt = r_copad_adr;
      for (int p = 0; p < 4; p++) begin
         if (w_pair_hit[p] && !r_gem_hit[p])    w_gem_adr_nxt[p]   = r_dadr;
         if (w_copad_hit[p] && !r_copad_hit[p]) w_copad_adr_nxt[p] = r_dadr;
      end
      // Copad outranks gem-only; the downward scan leaves the lowest pair index.
      w_idx  = 2'b00;
      w_pri  = 4'b0000;
      w_best = '0;
      if (|w_copad_nxt) begin
         for (int p = 3; p >= 0; p--) if (w_copad_nxt[p]) w_idx = 2'(p);
         w_pri  = {2'b11, w_idx};
         w_best = w_copad_adr_nxt[w_idx];
      end else if (|w_gem_nxt) begin
         for (int p = 3; p >= 0; p--) if (w_gem_nxt[p]) w_idx = 2'(p);
         w_pri  = {2'b10, w_idx};
         w_best = w_gem_adr_nxt[w_idx];
      end
   end

   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         r_state          <= StIdle;
         r_adr            <= '0;
         r_dvalid         <= 1'b0;
         r_dadr           <= '0;
         r_alct_vpf       <= '0;
         r_clct_vpf       <= '0;
         r_alct_wg        <= '0;
         r_clct_xky       <= '0;
         r_match_en       <= 1'b0;
         r_gem_hit        <= '0;
         r_copad_hit      <= '0;
         r_gem_adr        <= '0;
         r_copad_adr      <= '0;
         r_done           <= 1'b0;
         r_pair_gem_hit   <= '0;
         r_pair_copad_hit <= '0;
         r_pri_best       <= '0;
         r_best_cluster   <= '0;
         r_start_lost     <= 1'b0;
      end else begin
         r_state  <= w_state_nxt;
         r_dvalid <= o_clu_rd_en;
         r_dadr   <= r_adr;
         if (w_accept) begin
            r_adr       <= '0;
            r_alct_vpf  <= {i_alct1_vpf, i_alct0_vpf};
            r_clct_vpf  <= {i_clct1_vpf, i_clct0_vpf};
            r_alct_wg   <= {i_alct1_wg, i_alct0_wg};
            r_clct_xky  <= {i_clct1_xky, i_clct0_xky};
            r_match_en  <= i_match_en;
            r_gem_hit   <= '0;
            r_copad_hit <= '0;
            r_gem_adr   <= '0;
            r_copad_adr <= '0;
         end else begin
            if (o_clu_rd_en) r_adr <= r_adr + MXADR'(1);
            r_gem_hit   <= w_gem_nxt;
            r_copad_hit <= w_copad_nxt;
            r_gem_adr   <= w_gem_adr_nxt;
            r_copad_adr <= w_copad_adr_nxt;
         end
         // Results include the last-address data compared during DRAIN.
         r_done <= (r_state == StDrain);
         if (r_state == StDrain) begin
            r_pair_gem_hit   <= w_gem_nxt;
            r_pair_copad_hit <= w_copad_nxt;
            r_pri_best       <= w_pri;
            r_best_cluster   <= w_best;
         end
         if (i_start && o_busy) r_start_lost <= 1'b1;
      end
   end

   assign o_clu_rd_adr     = r_adr;
   assign o_done           = r_done;
   assign o_pair_gem_hit   = r_pair_gem_hit;
   assign o_pair_copad_hit = r_pair_copad_hit;
   assign o_pri_best       = r_pri_best;
   assign o_best_cluster   = r_best_cluster;
   assign o_start_lost     = r_start_lost;

endmodule

// File: tb/tb_gem_match_scheduler.sv
// Directed bench for gem_match_scheduler: cluster-buffer model plus a queue of expected
// walk results popped on each done strobe.
module tb_gem_match_scheduler;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       reset = 1'b1, start = 1'b0, match_en = 1'b1;
   logic       alct0_vpf = 1'b0, alct1_vpf = 1'b0, clct0_vpf = 1'b0, clct1_vpf = 1'b0;
   logic [6:0] alct0_wg = '0, alct1_wg = '0;
   logic [9:0] clct0_xky = '0, clct1_xky = '0;
   logic       rd_en;
   logic [3:0] rd_adr;
   logic       clu_vpf = 1'b0, clu_copad = 1'b0;
   logic [6:0] clu_wg_lo = '0, clu_wg_hi = '0;
   logic [9:0] clu_xky_lo = '0, clu_xky_hi = '0;
   logic       busy, done, start_lost;
   logic [3:0] pair_gem_hit, pair_copad_hit, pri_best, best_cluster;

   gem_match_scheduler dut (
      .i_clock         (clk),
      .i_reset         (reset),
      .i_start         (start),
      .i_match_en      (match_en),
      .i_alct0_vpf     (alct0_vpf),
      .i_alct1_vpf     (alct1_vpf),
      .i_alct0_wg      (alct0_wg),
      .i_alct1_wg      (alct1_wg),
      .i_clct0_vpf     (clct0_vpf),
      .i_clct1_vpf     (clct1_vpf),
      .i_clct0_xky     (clct0_xky),
      .i_clct1_xky     (clct1_xky),
      .o_clu_rd_en     (rd_en),
      .o_clu_rd_adr    (rd_adr),
      .i_clu_vpf       (clu_vpf),
      .i_clu_wg_lo     (clu_wg_lo),
      .i_clu_wg_hi     (clu_wg_hi),
      .i_clu_xky_lo    (clu_xky_lo),
      .i_clu_xky_hi    (clu_xky_hi),
      .i_clu_copad     (clu_copad),
      .o_busy          (busy),
      .o_done          (done),
      .o_pair_gem_hit  (pair_gem_hit),
      .o_pair_copad_hit(pair_copad_hit),
      .o_pri_best      (pri_best),
      .o_best_cluster  (best_cluster),
      .o_start_lost    (start_lost)
   );

   // Cluster buffer: one-cycle read latency, data holds when not read.
   logic       c_vpf [16];
   logic       c_cp  [16];
   logic [6:0] c_wl  [16];
   logic [6:0] c_wh  [16];
   logic [9:0] c_xl  [16];
   logic [9:0] c_xh  [16];

   always @(posedge clk) begin
      if (rd_en) begin
         clu_vpf    <= c_vpf[rd_adr];
         clu_copad  <= c_cp[rd_adr];
         clu_wg_lo  <= c_wl[rd_adr];
         clu_wg_hi  <= c_wh[rd_adr];
         clu_xky_lo <= c_xl[rd_adr];
         clu_xky_hi <= c_xh[rd_adr];
      end
   end

   typedef struct packed {
      logic [3:0] gem;
      logic [3:0] copad;
      logic [3:0] pri;
      logic [3:0] best;
   } exp_t;

   exp_t exp_q[$];
   int   checks = 0;
   int   errors = 0;
   logic [3:0] last_pri = '0, last_best = '0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Invalid clusters get all-covering windows so only the valid flag keeps them out.
   task automatic clear_clusters();
      for (int i = 0; i < 16; i++) begin
         c_vpf[i] = 1'b0; c_cp[i] = 1'b1;
         c_wl[i] = 7'd0;  c_wh[i] = 7'd127;
         c_xl[i] = 10'd0; c_xh[i] = 10'd1023;
      end
   endtask

   task automatic set_cl(input int a, input logic [6:0] wl, input logic [6:0] wh,
                         input logic [9:0] xl, input logic [9:0] xh, input logic cp);
      c_vpf[a] = 1'b1; c_cp[a] = cp;
      c_wl[a] = wl; c_wh[a] = wh; c_xl[a] = xl; c_xh[a] = xh;
   endtask

   task automatic set_lct(input logic a0v, input logic [6:0] a0w, input logic a1v,
                          input logic [6:0] a1w, input logic c0v, input logic [9:0] c0x,
                          input logic c1v, input logic [9:0] c1x, input logic men);
      alct0_vpf = a0v; alct0_wg = a0w; alct1_vpf = a1v; alct1_wg = a1w;
      clct0_vpf = c0v; clct0_xky = c0x; clct1_vpf = c1v; clct1_xky = c1x;
      match_en = men;
   endtask

   task automatic walk(input string name, input logic [3:0] eg, input logic [3:0] ec,
                       input logic [3:0] ep, input logic [3:0] eb, input int restart_at);
      exp_t e;
      int   done_at, done_cnt, busy_cnt;
      logic adr_ok;
      e.gem = eg; e.copad = ec; e.pri = ep; e.best = eb;
      exp_q.push_back(e);
      @(negedge clk);
      chk({name, ".idle_busy"}, busy, 0);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      done_at = 0; done_cnt = 0; busy_cnt = 0; adr_ok = 1'b1;
      for (int n = 1; n <= 18; n++) begin
         if (n > 1) @(negedge clk);
         start = (n == restart_at);
         if (n == 1) chk({name, ".hold"}, {pri_best, best_cluster}, {last_pri, last_best});
         if (busy === 1'b1) busy_cnt++;
         if (n <= 16 && !(rd_en === 1'b1 && rd_adr === 4'(n - 1))) adr_ok = 1'b0;
         if (n > 16 && rd_en !== 1'b0) adr_ok = 1'b0;
         if (done === 1'b1) begin
            done_cnt++;
            done_at = n;
            if (exp_q.size() > 0) begin
               e = exp_q.pop_front();
               chk({name, ".gem_hit"},   pair_gem_hit,   e.gem);
               chk({name, ".copad_hit"}, pair_copad_hit, e.copad);
               chk({name, ".pri_best"},  pri_best,       e.pri);
               chk({name, ".best_clu"},  best_cluster,   e.best);
            end
         end
      end
      start = 1'b0;
      chk({name, ".done_at"},  done_at,  18);
      chk({name, ".done_cnt"}, done_cnt, 1);
      chk({name, ".busy_cnt"}, busy_cnt, 18);
      chk({name, ".rd_seq"},   adr_ok,   1);
      if (done_cnt == 0 && exp_q.size() > 0) e = exp_q.pop_front();
      last_pri  = ep;
      last_best = eb;
   endtask

   task automatic check_zero(input string name);
      chk({name, ".busy"},   busy,           0);
      chk({name, ".done"},   done,           0);
      chk({name, ".rd_en"},  rd_en,          0);
      chk({name, ".rd_adr"}, rd_adr,         0);
      chk({name, ".gem"},    pair_gem_hit,   0);
      chk({name, ".copad"},  pair_copad_hit, 0);
      chk({name, ".pri"},    pri_best,       0);
      chk({name, ".best"},   best_cluster,   0);
      chk({name, ".lost"},   start_lost,     0);
   endtask

   initial begin
      int dcount;
      clear_clusters();
      repeat (3) @(negedge clk);
      check_zero("reset");
      reset = 1'b0;

      // gemA copad hit on a0c0
      set_lct(1, 7'd20, 0, 7'd0, 1, 10'd300, 0, 10'd0, 1);
      set_cl(3, 7'd18, 7'd22, 10'd290, 10'd310, 1);
      walk("t1", 4'b0001, 4'b0001, 4'b1100, 4'd3, 0);
      chk("t1.lost", start_lost, 0);

      // gemB copad flag ignored
      clear_clusters();
      set_cl(13, 7'd18, 7'd22, 10'd290, 10'd310, 1);
      walk("t2", 4'b0001, 4'b0000, 4'b1000, 4'd13, 0);

      // copad a1c1 outranks gem-only a0c0
      set_lct(1, 7'd20, 1, 7'd100, 1, 10'd300, 1, 10'd800, 1);
      clear_clusters();
      set_cl(1, 7'd18, 7'd22, 10'd290, 10'd310, 0);
      set_cl(6, 7'd95, 7'd105, 10'd790, 10'd810, 1);
      walk("t3", 4'b1001, 4'b1000, 4'b1111, 4'd6, 0);

      // gem-only: lowest pair index wins, first address kept
      clear_clusters();
      set_cl(2, 7'd95, 7'd105, 10'd290, 10'd310, 0);
      set_cl(4, 7'd18, 7'd22, 10'd790, 10'd810, 0);
      set_cl(9, 7'd18, 7'd22, 10'd790, 10'd810, 1);
      walk("t4", 4'b0110, 4'b0000, 4'b1001, 4'd4, 0);

      // top-of-range inclusive bounds
      set_lct(1, 7'd127, 0, 7'd0, 1, 10'd1023, 0, 10'd0, 1);
      clear_clusters();
      set_cl(0, 7'd127, 7'd127, 10'd1000, 10'd1023, 0);
      walk("t5", 4'b0001, 4'b0000, 4'b1000, 4'd0, 0);

      // just outside the window on each side
      set_lct(1, 7'd20, 0, 7'd0, 1, 10'd500, 0, 10'd0, 1);
      clear_clusters();
      set_cl(5, 7'd0, 7'd127, 10'd501, 10'd600, 1);
      set_cl(7, 7'd21, 7'd30, 10'd400, 10'd600, 1);
      set_cl(10, 7'd10, 7'd19, 10'd400, 10'd600, 0);
      walk("t6", 4'b0000, 4'b0000, 4'b0000, 4'd0, 0);

      // match disabled
      set_lct(1, 7'd20, 0, 7'd0, 1, 10'd300, 0, 10'd0, 0);
      clear_clusters();
      set_cl(3, 7'd18, 7'd22, 10'd290, 10'd310, 1);
      walk("t7", 4'b0000, 4'b0000, 4'b0000, 4'd0, 0);

      // restart at T+5 lost, then back-to-back walk
      match_en = 1'b1;
      walk("t8", 4'b0001, 4'b0001, 4'b1100, 4'd3, 5);
      chk("t8.lost", start_lost, 1);
      clear_clusters();
      set_cl(13, 7'd18, 7'd22, 10'd290, 10'd310, 1);
      walk("t9", 4'b0001, 4'b0000, 4'b1000, 4'd13, 0);

      // reset mid-walk
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (8) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      check_zero("rst_mid");
      reset = 1'b0;
      last_pri = '0; last_best = '0;
      dcount = 0;
      for (int n = 0; n < 25; n++) begin
         @(negedge clk);
         if (done === 1'b1) dcount++;
      end
      chk("rst_mid.no_done", dcount, 0);

      set_lct(1, 7'd20, 1, 7'd100, 1, 10'd300, 1, 10'd800, 1);
      clear_clusters();
      set_cl(1, 7'd18, 7'd22, 10'd290, 10'd310, 0);
      set_cl(6, 7'd95, 7'd105, 10'd790, 10'd810, 1);
      walk("t10", 4'b1001, 4'b1000, 4'b1111, 4'd6, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
